bru_resolve: RTL and testbench



---
 rtl/bru_pkg.sv | 37 +++
 rtl/bru_cond.sv | 28 ++
 rtl/bru_resolve.sv | 177 +++++++++++++++++
 tb/tb_bru_resolve.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared types for the branch resolution unit: branch opcodes, stage-1 payload and
// the mispredict rule.
package bru_pkg;

    typedef logic        u1;
    typedef logic [63:0] u64;

    typedef enum logic [3:0] {
        B_NONE = 4'd0,
        B_BEQ  = 4'd1,
        B_BNE  = 4'd2,
        B_BLT  = 4'd3,
        B_BGE  = 4'd4,
        B_BLTU = 4'd5,
        B_BGEU = 4'd6,
        B_JAL  = 4'd7,
        B_JALR = 4'd8
    } branch_t;

    localparam int unsigned ILEN_BYTES_DEFAULT = 4;

    // Address fields are held at 64 bits and zero-extended when XLEN is narrower.
    typedef struct packed {
        u1  taken;
        u64 target;
        u64 fallthrough;
        u1  pred_taken;
        u64 pred_target;
    } bru_s1_t;

    // The predicted target only matters when both actual and predicted are taken.
    function automatic u1 bru_mispredict(input bru_s1_t s);
        return (s.taken != s.pred_taken) |
               (s.taken & s.pred_taken & (s.target != s.pred_target));
    endfunction

endpackage

// File: rtl/bru_cond.sv
// Combinational branch condition evaluator.
module bru_cond
    import bru_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  branch_t          branch_type_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    output logic             taken_o
);

    always_comb begin
        taken_o = 1'b0;
        unique case (branch_type_i)
            B_BEQ:   taken_o = (a_i == b_i);
            B_BNE:   taken_o = (a_i != b_i);
            B_BLT:   taken_o = ($signed(a_i) < $signed(b_i));
            B_BGE:   taken_o = ($signed(a_i) >= $signed(b_i));
            B_BLTU:  taken_o = (a_i < b_i);
            B_BGEU:  taken_o = (a_i >= b_i);
            B_JAL:   taken_o = 1'b1;
            B_JALR:  taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/bru_resolve.sv
// Pipelined branch resolution unit with valid/ready on both sides (STAGES = 1 or 2).
// Optional BRU_STATS_EN adds saturating branch / mispredict counters.
module bru_resolve
    import bru_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned ILEN_BYTES = ILEN_BYTES_DEFAULT,
    parameter int unsigned STAGES     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  branch_t         in_branch_type,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_taken,
    input  logic [XLEN-1:0] in_pred_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_next_pc,
    output logic            out_mispredict
`ifdef BRU_STATS_EN
    ,
    output logic [63:0]     stat_branches,
    output logic [63:0]     stat_mispredicts
`endif
);

    localparam logic [XLEN-1:0] Bit0Clear = {{(XLEN-1){1'b1}}, 1'b0};

    logic            kill;
    logic            c_taken;
    logic [XLEN-1:0] c_target;
    logic [XLEN-1:0] c_fall;
    bru_s1_t         s0;
    bru_s1_t         src;
    logic            src_valid;
    logic            src_adv;
    logic            out_room;

    logic            out_valid_q;
    logic            out_taken_q;
    logic [XLEN-1:0] out_next_pc_q;
    logic            out_mispredict_q;

    assign kill = flush | reset;

    bru_cond #(.XLEN(XLEN)) u_cond (
        .branch_type_i (in_branch_type),
        .a_i           (in_a),
        .b_i           (in_b),
        .taken_o       (c_taken)
    );

    always_comb begin
        c_target = in_pc + in_imm;
        if (in_branch_type == B_JALR) c_target = (in_a + in_imm) & Bit0Clear;
        c_fall = in_pc + XLEN'(ILEN_BYTES);
    end

    assign s0 = '{taken:       c_taken,
                  target:      u64'(c_target),
                  fallthrough: u64'(c_fall),
                  pred_taken:  in_pred_taken,
                  pred_target: u64'(in_pred_target)};

    assign out_room = !out_valid_q | out_ready;
    assign src_adv  = src_valid & out_room;

`ifdef BRU_STATS_EN
    logic s0_is_br;
    logic src_is_br;
    logic out_is_br_q;
    assign s0_is_br = (in_branch_type != B_NONE);
`endif

    if (XLEN == 0 || XLEN > 64) begin : g_bad_xlen
        $error("bru_resolve: XLEN must be in 1..64");
    end

    if (STAGES == 2) begin : g_two
        bru_s1_t s1_q;
        logic    s1_valid_q;
        logic    accept;

        assign accept = in_valid & in_ready;

        always_ff @(posedge clk) begin
            if (reset) begin
                s1_valid_q <= 1'b0;
                s1_q       <= '0;
            end else begin
                if (flush)        s1_valid_q <= 1'b0;
                else if (accept)  s1_valid_q <= 1'b1;
                else if (src_adv) s1_valid_q <= 1'b0;
                if (accept) s1_q <= s0;
            end
        end

        assign src       = s1_q;
        assign src_valid = s1_valid_q;
        assign in_ready  = (!s1_valid_q | src_adv) & !kill;

`ifdef BRU_STATS_EN
        logic s1_is_br_q;
        always_ff @(posedge clk) begin
            if (reset)       s1_is_br_q <= 1'b0;
            else if (accept) s1_is_br_q <= s0_is_br;
        end
        assign src_is_br = s1_is_br_q;
`endif
    end else if (STAGES == 1) begin : g_one
        assign src       = s0;
        assign src_valid = in_valid & !kill;
        assign in_ready  = out_room & !kill;
`ifdef BRU_STATS_EN
        assign src_is_br = s0_is_br;
`endif
    end else begin : g_bad_stages
        $error("bru_resolve: STAGES must be 1 or 2");
    end

    // Output data only moves on a load, so it stays stable across a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q      <= 1'b0;
            out_taken_q      <= 1'b0;
            out_next_pc_q    <= '0;
            out_mispredict_q <= 1'b0;
        end else begin
            if (flush)          out_valid_q <= 1'b0;
            else if (src_adv)   out_valid_q <= 1'b1;
            else if (out_ready) out_valid_q <= 1'b0;
            if (src_adv) begin
                out_taken_q      <= src.taken;
                out_next_pc_q    <= src.taken ? src.target[XLEN-1:0]
                                              : src.fallthrough[XLEN-1:0];
                out_mispredict_q <= bru_mispredict(src);
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_taken      = out_taken_q;
    assign out_next_pc    = out_next_pc_q;
    assign out_mispredict = out_mispredict_q;

`ifdef BRU_STATS_EN
    logic        out_hs;
    logic [63:0] stat_br_q;
    logic [63:0] stat_mis_q;

    assign out_hs = out_valid_q & out_ready;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_is_br_q <= 1'b0;
            stat_br_q   <= '0;
            stat_mis_q  <= '0;
        end else begin
            if (src_adv) out_is_br_q <= src_is_br;
            if (out_hs && out_is_br_q && !(&stat_br_q))       stat_br_q  <= stat_br_q + 64'd1;
            if (out_hs && out_mispredict_q && !(&stat_mis_q)) stat_mis_q <= stat_mis_q + 64'd1;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_bru_resolve.sv
// Directed, table-driven bench for bru_resolve (STAGES=2, XLEN=64).
module tb_bru_resolve;
    import bru_pkg::*;

    typedef struct {
        branch_t     bt;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] pc;
        logic [63:0] imm;
        logic        pt;
        logic [63:0] ptgt;
        logic        et;
        logic [63:0] enpc;
        logic        em;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    branch_t     in_branch_type;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [63:0] in_pc;
    logic [63:0] in_imm;
    logic        in_pred_taken;
    logic [63:0] in_pred_target;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [63:0] out_next_pc;
    logic        out_mispredict;
`ifdef BRU_STATS_EN
    logic [63:0] stat_branches;
    logic [63:0] stat_mispredicts;
`endif

    int total = 0;
    int bad   = 0;
    vec_t vt[13];
    vec_t bb[11];

    bru_resolve #(.XLEN(64), .ILEN_BYTES(4), .STAGES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_branch_type (in_branch_type),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_pc          (in_pc),
        .in_imm         (in_imm),
        .in_pred_taken  (in_pred_taken),
        .in_pred_target (in_pred_target),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_taken      (out_taken),
        .out_next_pc    (out_next_pc),
        .out_mispredict (out_mispredict)
`ifdef BRU_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_branch_type = v.bt;
        in_a           = v.a;
        in_b           = v.b;
        in_pc          = v.pc;
        in_imm         = v.imm;
        in_pred_taken  = v.pt;
        in_pred_target = v.ptgt;
        in_valid       = 1'b1;
    endtask

    task automatic chk_out(input string name, input vec_t v);
        chk({name, ".taken"}, {63'd0, out_taken}, {63'd0, v.et});
        chk({name, ".next_pc"}, out_next_pc, v.enpc);
        chk({name, ".mispredict"}, {63'd0, out_mispredict}, {63'd0, v.em});
    endtask

    // Single isolated transaction: checks 2-cycle latency and result fields.
    task automatic run_vec(input int i);
        int lat;
        out_ready = 1'b1;
        drive(vt[i]);
        #1;
        chk($sformatf("v%0d.in_ready", i), {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk($sformatf("v%0d.latency", i), 64'(lat), 64'd2);
        chk_out($sformatf("v%0d", i), vt[i]);
        tick();
    endtask

    function automatic vec_t mk_beq(input int k);
        vec_t v;
        v.bt   = B_BEQ;
        v.a    = 64'(k);
        v.b    = (k % 3 == 0) ? 64'(k) : 64'(k + 1);
        v.pc   = 64'h1000 + 64'(16 * k);
        v.imm  = 64'h40;
        v.pt   = 1'b0;
        v.ptgt = 64'h0;
        v.et   = (k % 3 == 0);
        v.enpc = v.et ? v.pc + 64'h40 : v.pc + 64'h4;
        v.em   = v.et;
        return v;
    endfunction

    initial begin
        vt[0]  = '{B_BLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h1000, 64'h20, 1'b0, 64'h0,
                   1'b1, 64'h1020, 1'b1};
        vt[1]  = '{B_BLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h1000, 64'h20, 1'b0, 64'h0,
                   1'b0, 64'h1004, 1'b0};
        vt[2]  = '{B_JALR, 64'h2003, 64'd0, 64'h800, 64'h10, 1'b1, 64'h2012,
                   1'b1, 64'h2012, 1'b0};
        vt[3]  = '{B_JALR, 64'h2003, 64'd0, 64'h800, 64'h10, 1'b1, 64'h2014,
                   1'b1, 64'h2012, 1'b1};
        vt[4]  = '{B_BNE,  64'd5, 64'd5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h80, 1'b0, 64'h0,
                   1'b0, 64'h0, 1'b0};
        vt[5]  = '{B_BEQ,  64'd7, 64'd7, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 64'hF8,
                   1'b1, 64'hF8, 1'b0};
        vt[6]  = '{B_BGE,  64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB, 64'h200, 64'h40,
                   1'b1, 64'h300, 1'b1, 64'h240, 1'b1};
        vt[7]  = '{B_BGEU, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h300, 64'h40, 1'b1, 64'h340,
                   1'b0, 64'h304, 1'b1};
        vt[8]  = '{B_JAL,  64'd0, 64'd0, 64'h400, 64'h100, 1'b0, 64'h0,
                   1'b1, 64'h500, 1'b1};
        vt[9]  = '{B_NONE, 64'd3, 64'd3, 64'h500, 64'h10, 1'b0, 64'hDEAD,
                   1'b0, 64'h504, 1'b0};
        vt[10] = '{B_BNE,  64'd1, 64'd2, 64'h600, 64'h10, 1'b1, 64'h610,
                   1'b1, 64'h610, 1'b0};
        vt[11] = '{B_BLT,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h700, 64'h10, 1'b0, 64'h123,
                   1'b0, 64'h704, 1'b0};
        vt[12] = '{B_JAL,  64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 1'b1, 64'h10,
                   1'b1, 64'h10, 1'b0};
        for (int k = 0; k < 11; k++) bb[k] = mk_beq(k);

        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive(vt[0]);
        in_valid = 1'b0;
        tick();
        tick();
        chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst.out_taken", {63'd0, out_taken}, 64'd0);
        chk("rst.out_next_pc", out_next_pc, 64'd0);
        chk("rst.out_mispredict", {63'd0, out_mispredict}, 64'd0);
        chk("rst.in_ready", {63'd0, in_ready}, 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst.in_ready", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 13; i++) run_vec(i);

        // Back-to-back BEQ at full throughput.
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                drive(bb[c]);
                #1;
                chk($sformatf("b2b%0d.in_ready", c), {63'd0, in_ready}, 64'd1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c == 0) chk("b2b.first_empty", {63'd0, out_valid}, 64'd0);
            if (c >= 1 && c <= 8) begin
                chk($sformatf("b2b%0d.out_valid", c - 1), {63'd0, out_valid}, 64'd1);
                chk_out($sformatf("b2b%0d", c - 1), bb[c - 1]);
            end
            if (c == 9) chk("b2b.drained", {63'd0, out_valid}, 64'd0);
        end

        // Stall: fill both stages with out_ready low.
        out_ready = 1'b0;
        drive(bb[8]);
        #1;
        chk("stall.in_ready0", {63'd0, in_ready}, 64'd1);
        tick();
        drive(bb[9]);
        #1;
        chk("stall.in_ready1", {63'd0, in_ready}, 64'd1);
        tick();
        drive(bb[10]);
        for (int r = 0; r < 3; r++) begin
            #1;
            chk($sformatf("stall%0d.in_ready", r), {63'd0, in_ready}, 64'd0);
            chk($sformatf("stall%0d.out_valid", r), {63'd0, out_valid}, 64'd1);
            chk_out($sformatf("stall%0d", r), bb[8]);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("unstall.in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("unstall.v9_valid", {63'd0, out_valid}, 64'd1);
        chk_out("unstall.v9", bb[9]);
        tick();
        chk("unstall.v10_valid", {63'd0, out_valid}, 64'd1);
        chk_out("unstall.v10", bb[10]);
        tick();
        chk("unstall.drained", {63'd0, out_valid}, 64'd0);

        // Flush with two entries in flight plus a new input offered.
        drive(bb[0]);
        tick();
        drive(bb[1]);
        tick();
        drive(bb[2]);
        flush = 1'b1;
        #1;
        chk("flush.in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        for (int r = 0; r < 5; r++) begin
            chk($sformatf("flush%0d.out_valid", r), {63'd0, out_valid}, 64'd0);
            tick();
        end

        // Reset mid-operation, then counters over five transactions.
        drive(vt[6]);
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst.out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst.out_next_pc", out_next_pc, 64'd0);
        tick();
        chk("mid_rst.no_stale", {63'd0, out_valid}, 64'd0);
`ifdef BRU_STATS_EN
        chk("stat_br.reset", stat_branches, 64'd0);
        chk("stat_mis.reset", stat_mispredicts, 64'd0);
`endif
        for (int i = 0; i < 5; i++) run_vec(i);
`ifdef BRU_STATS_EN
        chk("stat_branches", stat_branches, 64'd5);
        chk("stat_mispredicts", stat_mispredicts, 64'd2);
        run_vec(9);
        chk("stat_branches.none", stat_branches, 64'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
